// File: rtl/sum_buf_pkg.sv
// Shared constants and types for the sum stream buffer.
package sum_buf_pkg;
    localparam int SIZE   = 4;
    localparam int DATA_W = SIZE + 1;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);

    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/sum_buf_regfile.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
module sum_buf_regfile
    import sum_buf_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int DEPTH_P  = DEPTH,
    parameter int PTR_W_P  = PTR_W
) (
    input  logic                clk,
    input  logic                we,
    input  logic [PTR_W_P-1:0]  waddr,
    input  logic [DATA_W_P-1:0] wdata,
    input  logic [PTR_W_P-1:0]  raddr,
    output logic [DATA_W_P-1:0] rdata
);
    // Storage is intentionally not reset; out_valid gates its use.
    logic [DATA_W_P-1:0] mem [DEPTH_P];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sum_stream_buffer.sv
// Captures adder sums into a small FIFO and drains them over valid/ready,
// with a sticky overflow flag for samples dropped while full.
module sum_stream_buffer
    import sum_buf_pkg::*;
#(
    parameter int SIZE_P  = SIZE,
    parameter int DEPTH_P = DEPTH,
    parameter int CNT_W_P = CNT_W
) (
    input  logic               clk,
    input  logic               rst_a,
    input  logic               enable,
    input  logic               in_valid,
    input  logic [SIZE_P:0]    in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SIZE_P:0]    out_data,
    output logic [CNT_W_P-1:0] count,
    output logic               full,
    output logic               overflow,
    input  logic               clr_ovf
);
    localparam int PW = $clog2(DEPTH_P);

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [SIZE_P:0] rdata;
    logic            push;
    logic            pop;

    assign out_valid = (count != '0);
    assign full      = (count == CNT_W_P'(DEPTH_P));
    assign out_data  = out_valid ? rdata : '0;

    assign pop  = enable & out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = enable & in_valid & (~full | pop);

    sum_buf_regfile #(
        .DATA_W_P(SIZE_P + 1),
        .DEPTH_P (DEPTH_P),
        .PTR_W_P (PW)
    ) u_regfile (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(in_data),
        .raddr(rd_ptr),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_a) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (enable) begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // Set has priority over clear.
            if (in_valid && full && !pop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sum_stream_buffer.sv
// Self-checking bench: directed vector table, wrap/freeze sequence and
// randomized traffic against a queue-based reference model.
module tb_sum_stream_buffer;
    logic       clk = 1'b0;
    logic       rst_a, enable, in_valid, out_ready, clr_ovf;
    logic [4:0] in_data;
    logic       out_valid, full, overflow;
    logic [4:0] out_data;
    logic [2:0] count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sum_stream_buffer dut (
        .clk(clk), .rst_a(rst_a), .enable(enable), .in_valid(in_valid),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .count(count), .full(full),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    typedef struct {
        logic       rst_a, en, iv;
        logic [4:0] d;
        logic       rdy, clr;
        logic [2:0] e_cnt;
        logic       e_val;
        logic [4:0] e_data;
        logic       e_full, e_ovf;
    } vec_t;

    vec_t vecs[$];

    // Reference model: FIFO contents as a queue plus a sticky bit.
    logic [4:0] mq[$];
    logic       m_ovf;
    logic [4:0] got[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic iv,
                         input logic [4:0] d, input logic rdy, input logic c);
        rst_a = r; enable = e; in_valid = iv; in_data = d;
        out_ready = rdy; clr_ovf = c;
    endtask

    task automatic model_step();
        bit m_full, m_pop;
        if (!rst_a) begin
            mq.delete();
            m_ovf = 1'b0;
        end else if (enable) begin
            m_full = (mq.size() == 4);
            m_pop  = (mq.size() > 0) && out_ready;
            if (m_pop) void'(mq.pop_front());
            if (in_valid && (!m_full || m_pop)) mq.push_back(in_data);
            if (in_valid && m_full && !m_pop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, ".count"}, int'(count), mq.size());
        chk({tag, ".valid"}, int'(out_valid), int'(mq.size() > 0));
        chk({tag, ".data"},  int'(out_data), (mq.size() > 0) ? int'(mq[0]) : 0);
        chk({tag, ".full"},  int'(full), int'(mq.size() == 4));
        chk({tag, ".ovf"},   int'(overflow), int'(m_ovf));
    endtask

    // Applies current inputs for one clock, logs DUT pops, checks vs model.
    task automatic model_cycle(input string tag);
        #1;
        if (rst_a && enable && out_valid && out_ready) got.push_back(out_data);
        model_step();
        @(posedge clk);
        #1;
        model_check(tag);
    endtask

    task automatic addv(input logic r, e, iv, input logic [4:0] d,
                        input logic rdy, c, input logic [2:0] ec,
                        input logic ev, input logic [4:0] ed,
                        input logic ef, eo);
        vec_t v;
        v.rst_a = r; v.en = e; v.iv = iv; v.d = d; v.rdy = rdy; v.clr = c;
        v.e_cnt = ec; v.e_val = ev; v.e_data = ed; v.e_full = ef; v.e_ovf = eo;
        vecs.push_back(v);
    endtask

    initial begin
        int next_in;
        drive(0, 1, 1, 5'h1F, 0, 0);
        m_ovf = 1'b0;

        // rst, en, iv, data, rdy, clr | count, valid, data, full, ovf
        addv(0,1,1,5'h1F,0,0, 0,0,5'h00,0,0);
        addv(0,1,1,5'h1F,0,0, 0,0,5'h00,0,0);
        addv(1,1,1,5'h03,0,0, 1,1,5'h03,0,0);
        addv(1,1,1,5'h07,0,0, 2,1,5'h03,0,0);
        addv(1,1,1,5'h0C,0,0, 3,1,5'h03,0,0);
        addv(1,1,1,5'h1E,0,0, 4,1,5'h03,1,0);
        addv(1,1,1,5'h11,0,0, 4,1,5'h03,1,1);
        addv(1,1,1,5'h11,0,1, 4,1,5'h03,1,1);
        addv(1,1,0,5'h00,0,1, 4,1,5'h03,1,0);
        addv(1,1,0,5'h00,1,0, 3,1,5'h07,0,0);
        addv(1,1,0,5'h00,1,0, 2,1,5'h0C,0,0);
        addv(1,1,0,5'h00,1,0, 1,1,5'h1E,0,0);
        addv(1,1,0,5'h00,1,0, 0,0,5'h00,0,0);
        addv(1,1,1,5'h01,0,0, 1,1,5'h01,0,0);
        addv(1,1,1,5'h02,0,0, 2,1,5'h01,0,0);
        addv(1,1,1,5'h03,0,0, 3,1,5'h01,0,0);
        addv(1,1,1,5'h04,0,0, 4,1,5'h01,1,0);
        addv(1,1,1,5'h15,1,0, 4,1,5'h02,1,0);
        addv(1,1,0,5'h00,1,0, 3,1,5'h03,0,0);
        addv(1,1,0,5'h00,1,0, 2,1,5'h04,0,0);
        addv(1,1,0,5'h00,1,0, 1,1,5'h15,0,0);
        addv(1,1,0,5'h00,1,0, 0,0,5'h00,0,0);
        addv(1,1,1,5'h0A,0,0, 1,1,5'h0A,0,0);
        addv(1,0,1,5'h1F,1,1, 1,1,5'h0A,0,0);
        addv(1,0,1,5'h1F,1,1, 1,1,5'h0A,0,0);
        addv(1,1,1,5'h0B,0,0, 2,1,5'h0A,0,0);
        addv(0,1,1,5'h1F,1,0, 0,0,5'h00,0,0);

        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst_a, vecs[i].en, vecs[i].iv, vecs[i].d,
                  vecs[i].rdy, vecs[i].clr);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.count", i), int'(count), int'(vecs[i].e_cnt));
            chk($sformatf("vec%0d.valid", i), int'(out_valid), int'(vecs[i].e_val));
            chk($sformatf("vec%0d.data",  i), int'(out_data), int'(vecs[i].e_data));
            chk($sformatf("vec%0d.full",  i), int'(full), int'(vecs[i].e_full));
            chk($sformatf("vec%0d.ovf",   i), int'(overflow), int'(vecs[i].e_ovf));
        end

        // Model is in sync: the last vector left the DUT in reset state.
        mq.delete();
        m_ovf = 1'b0;
        got.delete();

        // Stream 0..9 with toggling ready and a 3-cycle enable drop.
        next_in = 0;
        for (int cyc = 0; cyc < 200 && got.size() < 10; cyc++) begin
            logic rdy, en, iv;
            rdy = cyc[0];
            en  = !(cyc >= 6 && cyc < 9);
            iv  = (next_in < 10) && ((mq.size() < 4) || (rdy && mq.size() > 0));
            drive(1, en, iv, 5'(next_in), rdy, 0);
            if (en && iv) next_in++;
            model_cycle("wrap");
        end
        chk("wrap.n", got.size(), 10);
        foreach (got[i]) chk($sformatf("wrap.order%0d", i), int'(got[i]), i);

        // Randomized traffic.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 9) < 6), 5'($urandom),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0));
            model_cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sum_stream_buffer.md
Name: sum_stream_buffer

Overview:
- Downstream consumer of the registered-adder stage.
- Captures each (SIZE+1)-bit sum the adder produces into a small synchronous FIFO when strobed valid, then drains it to the next stage over a valid/ready handshake.
- Decouples the free-running adder from a back-pressuring consumer.
- Flags lost samples with a sticky overflow bit.

Parameters:
- SIZE, 4: MSB index of the sum; data width is SIZE+1 = 5 bits.
- DEPTH, 4: FIFO entries; must be a power of two, at least 2.
- CNT_W, 3: width of the occupancy count; equals clog2(DEPTH+1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_a  input  1  reset; synchronous, active-low.
- enable  input  1  global clock-enable; when low, all state holds.
- in_valid  input  1  qualifies in_data this cycle.
- in_data  input  SIZE+1  sum from the upstream adder stage.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts head this cycle.
- out_data  output  SIZE+1  FIFO head data.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; set when a valid sample is dropped.
- clr_ovf  input  1  single-cycle clear of overflow.

Behaviour:
- Reset (rst_a low at a clk edge): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Outputs are then out_valid=0, out_data=0, full=0. Storage array is not reset. Reset dominates enable and every other input; a reset mid-drain discards all contents.
- enable low: no push, no pop, no flag update; all outputs hold their values.
- pop = enable & out_valid & out_ready.
- push = enable & in_valid & (~full | pop). When full, a simultaneous pop frees a slot and the sample is accepted.
- Memory write: on push, mem[wr_ptr] <= in_data and wr_ptr <= wr_ptr+1, wrapping modulo DEPTH (natural binary wrap).
- Read side: on pop, rd_ptr <= rd_ptr+1, with the same wrap.
- count update:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- out_valid = (count != 0), decoded from registered count.
- out_data = mem[rd_ptr] when out_valid, else 0. This is a combinational read of the register array; there is no fall-through.
- Latency: a sample pushed in cycle N is visible on out_data/out_valid in cycle N+1. Pushing into an empty FIFO gives out_valid high in N+1.
- full = (count == DEPTH).
- overflow:
  - Set when enable & in_valid & full & ~pop.
  - Cleared by enable & clr_ovf.
  - If set and clear occur in the same cycle, set wins.
  - Held otherwise.
- Dropped samples are discarded; FIFO contents are unaffected.
- Width: data passes through unmodified with no arithmetic. count is unsigned and never exceeds DEPTH.

Decomposition:
- Package sum_buf_pkg holds:
  - constants SIZE=4, DATA_W=SIZE+1, DEPTH=4, CNT_W=clog2(DEPTH+1), PTR_W=clog2(DEPTH)
  - typedef data_t = logic [DATA_W-1:0]
- One natural sub-module, sum_buf_regfile:
  - DEPTH x DATA_W register array
  - synchronous write port (we, waddr, wdata)
  - asynchronous read port (raddr, rdata)
- Pointers, count, flags and handshake logic stay in the top.

Test Plan:
- Reset and hold: rst_a=0 for 2 cycles with in_valid=1, in_data=5'h1F, then release with enable=1 and out_ready=0 -> during reset count=0, out_valid=0, out_data=0, overflow=0.
- Fill and drain order: push 5'h03, 5'h07, 5'h0C, 5'h1E with out_ready=0 -> count=4, full=1. Then out_ready=1 -> out_data reads 03, 07, 0C, 1E on consecutive cycles, then out_valid=0 and count=0.
- Overflow: with the FIFO full, push 5'h11 with out_ready=0 -> overflow=1, count stays 4, and the drained data excludes 5'h11. Pulse clr_ovf -> overflow=0 next cycle.
- Full with simultaneous push and pop: full FIFO, in_valid=1, in_data=5'h15, out_ready=1 -> count stays 4, overflow stays 0, and 5'h15 emerges fourth after draining.
- Wrap and enable: stream 10 samples 0..9 with out_ready toggling 1/0 -> output order is exactly 0..9 across pointer wrap. Drop enable for 3 cycles mid-stream -> count, out_data and overflow are frozen.
- Set/clear collision: FIFO full, in_valid=1, out_ready=0, clr_ovf=1 in the same cycle -> overflow=1.
